// File: rtl/ir_packet_tx.sv
// ir_packet_tx: parametrised IR remote-control packet transmitter.
// Frame: START burst, gap, CAR_SELECT burst, gap, then NUM_CMD_BITS command
// fields (ASSERT or DEASSERT burst + gap each, LSB first). Burst/gap sizes are
// in carrier periods and latched with COMMAND on the accept cycle.
// Ports:
//   CLK, RESET            clock, asynchronous active-high reset
//   SEND_PACKET, ABORT    start request (ignored while busy), abort in progress
//   COMMAND               command bits, bit i -> command field i
//   *_SIZE                burst/gap lengths in carrier periods (0 acts as 1)
//   IR_LED, CARRIER_EN    registered modulated LED drive, burst indicator
//   BUSY, DONE            packet in progress, one-cycle completion pulse
module ir_packet_tx #(
  parameter int NUM_CMD_BITS        = 4,
  parameter int COUNTER_WIDTH       = 12,
  parameter int CARRIER_HALF_PERIOD = 1389
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     SEND_PACKET,
  input  logic                     ABORT,
  input  logic [NUM_CMD_BITS-1:0]  COMMAND,
  input  logic [COUNTER_WIDTH-1:0] START_SIZE,
  input  logic [COUNTER_WIDTH-1:0] SELECT_SIZE,
  input  logic [COUNTER_WIDTH-1:0] GAP_SIZE,
  input  logic [COUNTER_WIDTH-1:0] ASSERT_SIZE,
  input  logic [COUNTER_WIDTH-1:0] DEASSERT_SIZE,
  output logic                     IR_LED,
  output logic                     CARRIER_EN,
  output logic                     BUSY,
  output logic                     DONE
);

  localparam int CW = COUNTER_WIDTH;
  localparam int FW = $clog2(NUM_CMD_BITS + 2);
  localparam logic [CW-1:0] ONE         = CW'(1);
  localparam logic [CW-1:0] HALF        = CW'(CARRIER_HALF_PERIOD);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(2 * CARRIER_HALF_PERIOD - 1);
  localparam logic [FW-1:0] FIELD_CMD0  = FW'(2);
  localparam logic [FW-1:0] FIELD_LAST  = FW'(NUM_CMD_BITS + 1);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

  state_t                  r_state, w_state_n;
  logic [CW-1:0]           r_phase, w_phase_n;
  logic [CW-1:0]           r_periods, w_periods_n;
  logic [FW-1:0]           r_field, w_field_n;
  logic [NUM_CMD_BITS-1:0] r_cmd;
  logic [CW-1:0]           r_start, r_select, r_gap, r_assert, r_deassert;
  logic                    r_ir_led, r_carrier_en, r_busy, r_done;
  logic                    w_done_n;
  logic [CW-1:0]           w_burst_len, w_seg_len;
  logic                    w_period_end, w_seg_end, w_cmd_shift;

  function automatic logic [CW-1:0] min1(input logic [CW-1:0] v);
    return (v == '0) ? ONE : v;
  endfunction

  // Command bits are consumed LSB first by shifting after each command gap,
  // so the current command field always reads r_cmd[0].
  always_comb begin
    w_burst_len = (r_field == '0)            ? r_start  :
                  (r_field == FW'(1))        ? r_select :
                  r_cmd[0]                   ? r_assert : r_deassert;
    w_seg_len    = (r_state == S_GAP) ? r_gap : w_burst_len;
    w_period_end = (r_phase == PERIOD_LAST);
    w_seg_end    = w_period_end && (r_periods == w_seg_len - ONE);
    w_cmd_shift  = (r_state == S_GAP) && w_seg_end && (r_field >= FIELD_CMD0);
  end

  always_comb begin
    w_state_n   = r_state;
    w_phase_n   = r_phase;
    w_periods_n = r_periods;
    w_field_n   = r_field;
    w_done_n    = 1'b0;

    if (r_state != S_IDLE) begin
      w_phase_n   = w_period_end ? '0 : r_phase + ONE;
      w_periods_n = w_seg_end ? '0 : (w_period_end ? r_periods + ONE : r_periods);
    end

    case (r_state)
      S_IDLE: begin
        if (SEND_PACKET) begin
          w_state_n   = S_BURST;
          w_phase_n   = '0;
          w_periods_n = '0;
          w_field_n   = '0;
        end
      end
      S_BURST: begin
        if (w_seg_end) w_state_n = S_GAP;
      end
      S_GAP: begin
        if (w_seg_end) begin
          if (r_field == FIELD_LAST) begin
            w_state_n = S_IDLE;
            w_field_n = '0;
            w_done_n  = 1'b1;
          end else begin
            w_state_n = S_BURST;
            w_field_n = r_field + FW'(1);
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    if (ABORT && (r_state != S_IDLE)) begin
      w_state_n   = S_IDLE;
      w_phase_n   = '0;
      w_periods_n = '0;
      w_field_n   = '0;
      w_done_n    = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_phase   <= '0;
      r_periods <= '0;
      r_field   <= '0;
    end else begin
      r_state   <= w_state_n;
      r_phase   <= w_phase_n;
      r_periods <= w_periods_n;
      r_field   <= w_field_n;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cmd      <= '0;
      r_start    <= '0;
      r_select   <= '0;
      r_gap      <= '0;
      r_assert   <= '0;
      r_deassert <= '0;
    end else if ((r_state == S_IDLE) && SEND_PACKET) begin
      r_cmd      <= COMMAND;
      r_start    <= min1(START_SIZE);
      r_select   <= min1(SELECT_SIZE);
      r_gap      <= min1(GAP_SIZE);
      r_assert   <= min1(ASSERT_SIZE);
      r_deassert <= min1(DEASSERT_SIZE);
    end else if (w_cmd_shift) begin
      r_cmd <= r_cmd >> 1;
    end
  end

  // Outputs are registered from the next-state values so they line up with
  // the state/phase they describe and never glitch.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_ir_led     <= 1'b0;
      r_carrier_en <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_carrier_en <= (w_state_n == S_BURST);
      r_ir_led     <= (w_state_n == S_BURST) && (w_phase_n < HALF);
      r_busy       <= (w_state_n != S_IDLE);
      r_done       <= w_done_n;
    end
  end

  assign IR_LED     = r_ir_led;
  assign CARRIER_EN = r_carrier_en;
  assign BUSY       = r_busy;
  assign DONE       = r_done;

endmodule

// File: tb/tb_ir_packet_tx.sv
module tb_ir_packet_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        send, abort;
  logic [3:0]  cmd;
  logic [11:0] start_sz, select_sz, gap_sz, assert_sz, deassert_sz;
  logic        led, cen, busy, done;

  logic        send0, abort0;
  logic [0:0]  cmd0;
  logic [11:0] zsz;
  logic        led0, cen0, busy0, done0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ir_packet_tx #(.NUM_CMD_BITS(4), .COUNTER_WIDTH(12), .CARRIER_HALF_PERIOD(2)) u_dut (
    .CLK(clk), .RESET(rst), .SEND_PACKET(send), .ABORT(abort), .COMMAND(cmd),
    .START_SIZE(start_sz), .SELECT_SIZE(select_sz), .GAP_SIZE(gap_sz),
    .ASSERT_SIZE(assert_sz), .DEASSERT_SIZE(deassert_sz),
    .IR_LED(led), .CARRIER_EN(cen), .BUSY(busy), .DONE(done)
  );

  ir_packet_tx #(.NUM_CMD_BITS(1), .COUNTER_WIDTH(12), .CARRIER_HALF_PERIOD(1)) u_dut0 (
    .CLK(clk), .RESET(rst), .SEND_PACKET(send0), .ABORT(abort0), .COMMAND(cmd0),
    .START_SIZE(zsz), .SELECT_SIZE(zsz), .GAP_SIZE(zsz),
    .ASSERT_SIZE(zsz), .DEASSERT_SIZE(zsz),
    .IR_LED(led0), .CARRIER_EN(cen0), .BUSY(busy0), .DONE(done0)
  );

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed {busy,done,cen,led}=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Basic packet, cycle c after accept: segments in periods (burst, gap, ...)
  // START 3, SELECT 1, bits 0101 -> 2,1,2,1; gap 2; 4 cycles per period.
  function automatic logic [3:0] pkt_exp(input int c);
    int seg [12];
    int e, p, ph, acc;
    logic burst, found;
    seg = '{3, 2, 1, 2, 2, 2, 1, 2, 2, 2, 1, 2};
    if (c >= 1 && c <= 88) begin
      e = c - 1; p = e / 4; ph = e % 4; acc = 0;
      burst = 1'b0; found = 1'b0;
      for (int i = 0; i < 12; i++) begin
        if (!found && p < acc + seg[i]) begin
          burst = (i % 2 == 0);
          found = 1'b1;
        end
        acc += seg[i];
      end
      return {1'b1, 1'b0, burst, burst && (ph < 2)};
    end
    if (c == 89) return 4'b0100;
    return 4'b0000;
  endfunction

  // Zero sizes, one command bit, half period 1: six 2-cycle periods.
  function automatic logic [3:0] zexp(input int c);
    int e;
    logic burst;
    if (c >= 1 && c <= 12) begin
      e = c - 1;
      burst = ((e / 2) % 2 == 0);
      return {1'b1, 1'b0, burst, burst && (e % 2 == 0)};
    end
    if (c == 13) return 4'b0100;
    return 4'b0000;
  endfunction

  // mode 0 basic, 1 latching, 2 busy-ignore, 3 back-to-back, 4 abort at T+30
  task automatic run_main(input int mode, input int ncyc);
    int rises, busy_cnt;
    logic prev_led;
    logic [3:0] e;
    rises = 0; busy_cnt = 0; prev_led = 1'b0;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (mode == 3 && c > 89)      e = pkt_exp(c - 89);
      else if (mode == 4 && c > 30) e = 4'b0000;
      else                          e = pkt_exp(c);
      check4($sformatf("mode%0d_cyc%0d", mode, c), {busy, done, cen, led}, e);
      if (led && !prev_led) rises++;
      prev_led = led;
      if (busy) busy_cnt++;
      send = 1'b0; abort = 1'b0;
      if (mode == 1 && c == 5) begin cmd = 4'b1111; assert_sz = 12'd9; end
      if (mode == 2 && (c == 20 || c == 60)) send = 1'b1;
      if (mode == 3 && c == 89) send = 1'b1;
      if (mode == 4 && c == 30) abort = 1'b1;
      @(negedge clk);
    end
    if (mode == 0) begin
      check_int("led_rising_edges", rises, 10);
      check_int("busy_cycles", busy_cnt, 88);
    end
    send = 1'b0; abort = 1'b0;
    cmd = 4'b0101; assert_sz = 12'd2;
  endtask

  initial begin
    rst = 1'b1; send = 1'b0; abort = 1'b0;
    cmd = 4'b0101; start_sz = 12'd3; select_sz = 12'd1; gap_sz = 12'd2;
    assert_sz = 12'd2; deassert_sz = 12'd1;
    send0 = 1'b0; abort0 = 1'b0; cmd0 = 1'b1; zsz = '0;

    repeat (3) @(negedge clk);
    check4("reset_dut", {busy, done, cen, led}, 4'b0000);
    check4("reset_dut0", {busy0, done0, cen0, led0}, 4'b0000);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_main(0, 95);
    run_main(1, 95);
    run_main(2, 100);
    run_main(3, 185);
    run_main(4, 100);

    // ABORT together with SEND in IDLE: packet accepted, then aborted
    send = 1'b1; abort = 1'b1;
    @(negedge clk);
    check4("abort_send_idle", {busy, done, cen, led}, 4'b1011);
    send = 1'b0; abort = 1'b1;
    @(negedge clk);
    check4("abort_after_accept", {busy, done, cen, led}, 4'b0000);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    check4("abort_no_done", {busy, done, cen, led}, 4'b0000);

    // Asynchronous reset in the first gap (cycles 13..20)
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    repeat (14) @(negedge clk);
    check4("pre_async_reset_gap", {busy, done, cen, led}, 4'b1000);
    #2 rst = 1'b1;
    #1 check4("async_reset_immediate", {busy, done, cen, led}, 4'b0000);
    #1 rst = 1'b0;
    @(negedge clk);
    check4("after_async_reset", {busy, done, cen, led}, 4'b0000);
    repeat (2) @(negedge clk);

    // Zero sizes on the one-bit instance
    send0 = 1'b1;
    @(negedge clk);
    send0 = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      check4($sformatf("zero_cyc%0d", c), {busy0, done0, cen0, led0}, zexp(c));
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ir_packet_tx.md
Name: ir_packet_tx

Overview:
- Parametrised IR remote-control packet transmitter. It is the next generation of the car IR transmitter state machine.
- Frame: START burst, gap, CAR_SELECT burst, gap, then NUM_CMD_BITS command fields. Each command field is an assert or deassert burst followed by a gap.
- Generates its own carrier. Burst and gap sizes are runtime inputs, so one instance drives any car colour.
- Adds a BUSY/DONE handshake, command latching and ABORT. Sits between the command/bus interface and the IR LED pin.

Parameters:
- NUM_CMD_BITS, 4, number of command fields per packet; minimum 1.
- COUNTER_WIDTH, 12, width of the size inputs and of the carrier-period counter.
- CARRIER_HALF_PERIOD, 1389, CLK cycles per carrier half-period (100 MHz / 36 kHz); minimum 1.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- SEND_PACKET  in  1  start request; sampled every cycle.
- ABORT  in  1  synchronous abort of a packet in progress.
- COMMAND  in  NUM_CMD_BITS  command bits; bit i drives field i, LSB transmitted first.
- START_SIZE  in  COUNTER_WIDTH  start burst length, in carrier periods.
- SELECT_SIZE  in  COUNTER_WIDTH  car-select burst length, in carrier periods.
- GAP_SIZE  in  COUNTER_WIDTH  gap length after every burst, in carrier periods.
- ASSERT_SIZE  in  COUNTER_WIDTH  burst length for a command bit of 1.
- DEASSERT_SIZE  in  COUNTER_WIDTH  burst length for a command bit of 0.
- IR_LED  out  1  modulated LED drive (registered).
- CARRIER_EN  out  1  high during burst phases (registered).
- BUSY  out  1  high while a packet is in progress.
- DONE  out  1  one-cycle pulse when a packet completes.

Behaviour:
- Reset: asynchronous, forces state IDLE. IR_LED, CARRIER_EN, BUSY and DONE are 0. All counters are 0.
- Accept: SEND_PACKET=1 in IDLE is the accept cycle T.
  - COMMAND and all five size inputs are latched at T. Later changes to them have no effect on the packet.
  - SEND_PACKET while BUSY=1 is ignored; there is no queueing.
- States: IDLE, BURST, GAP.
- Field index f runs 0..NUM_CMD_BITS+1.
  - f=0 is START; f=1 is CAR_SELECT; f=k+2 is command bit k.
  - Burst length: f=0 uses START_SIZE, f=1 uses SELECT_SIZE, otherwise ASSERT_SIZE if the bit is 1, else DEASSERT_SIZE.
  - Any latched size of 0 is treated as 1.
- Carrier divider:
  - The phase counter restarts at 0 at T+1 and at every BURST/GAP boundary.
  - One carrier period is 2*CARRIER_HALF_PERIOD cycles.
  - Within each period, the first CARRIER_HALF_PERIOD cycles are carrier-high, the rest carrier-low.
- Transitions:
  - IDLE to BURST(f=0) at T+1.
  - BURST to GAP after the burst length in carrier periods.
  - GAP to BURST(f+1) after GAP_SIZE periods.
  - GAP of the last field to IDLE.
- Outputs:
  - CARRIER_EN = 1 exactly while in BURST.
  - IR_LED = CARRIER_EN and carrier-high, registered and glitch-free. It is never the raw CLK.
- BUSY: 1 from T+1 through the last GAP cycle.
- DONE: 1 for exactly one cycle, on the first IDLE cycle after the final gap, with BUSY=0 in that cycle.
  - A SEND_PACKET in that DONE cycle is accepted. The next packet starts the following cycle.
- ABORT=1 while BUSY=1:
  - Next cycle is IDLE; IR_LED, CARRIER_EN and BUSY are 0; no DONE pulse.
  - ABORT in IDLE is ignored.
  - Simultaneous ABORT and SEND_PACKET in IDLE: the packet is accepted.
- Total packet length in carrier periods:
  - START + SELECT + (NUM_CMD_BITS+2)*GAP + sum over the command bits of (bit ? ASSERT : DEASSERT).
  - Multiply by 2*CARRIER_HALF_PERIOD for CLK cycles.
- Period counters do not wrap. The maximum size is 2^COUNTER_WIDTH-1 periods.

Test Plan:
- Basic packet: HALF=2, NUM_CMD_BITS=4, START=3, SELECT=1, GAP=2, ASSERT=2, DEASSERT=1, COMMAND=4'b0101, SEND at T.
  - Required: BUSY high for T+1..T+88 (22 periods x 4 cycles); DONE single pulse at T+89.
  - IR_LED rising edges: 3, 1, 2, 1, 2, 1 per burst.
  - Each carrier high pulse is 2 cycles.
- Latching: change COMMAND to 4'b1111 and ASSERT to 9 at T+5.
  - Required: waveform identical to the basic-packet test.
- Busy ignore: pulse SEND_PACKET at T+20 and T+60.
  - Required: one packet only; a single DONE at T+89.
- Back-to-back: assert SEND in the DONE cycle.
  - Required: second packet BUSY rises the next cycle; CARRIER_EN high for its first START burst.
- Abort/reset: ABORT at T+30.
  - Required: IR_LED=CARRIER_EN=BUSY=0 at T+31; DONE never asserts.
  - Repeat with asynchronous RESET mid-GAP: all outputs 0 immediately, without waiting for a CLK edge.
- Zero sizes: all sizes 0, NUM_CMD_BITS=1, HALF=1.
  - Required: each field lasts one period; BUSY for 6 periods (12 cycles); DONE at T+13.
